mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller for the E stage of the pipelined MIPS core.
- Accepts one operation per start pulse and computes the result internally.
- Holds busy for a fixed latency, then commits the result to the HI/LO registers.
- Exports stall_req so the hazard/forwarding controller can hold MDU-class instructions in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request from the E stage; qualifies op.
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op.
- a  input  32  rs operand, already forwarded.
- b  input  32  rt operand, already forwarded.
- busy  output  1  high while a mult/div is in flight.
- stall_req  output  1  start&(op<=3) | busy; combinational.
- hi  output  32  HI register.
- lo  output  32  LO register.
- done  output  1  one-cycle pulse in the cycle HI/LO are committed.

Behaviour:
- Reset (async, reset==0):
  - State=IDLE; counter=0; hi=lo=busy=done=0; pending result=0.
  - Asserting reset mid-operation aborts it; no commit occurs.
- States: IDLE, RUN.
- IDLE with start=1 and op in 0..3:
  - Compute the 64-bit result {rhi,rlo} from a and b, latched at this edge into pending registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- Timing for a start in cycle T:
  - busy=1 in cycles T+1..T+N.
  - hi/lo take the new values at the edge ending T+N, visible from T+N+1.
  - done=1 in cycle T+N+1; busy=0 from T+N+1.
- RUN: counter decrements each cycle; when counter==1, the edge commits hi/lo, clears busy, sets done and returns to IDLE.
- IDLE with start=1 and op 4 (mthi) or 5 (mtlo): hi<=a or lo<=a at that edge; no busy; done stays 0.
- start with op 6/7: ignored.
- start while busy (any op): ignored, with no state change. Correct RTL upstream never issues this, because the hazard unit stalls on stall_req.
- Arithmetic:
  - mult: signed 32x32 to 64; hi = upper 32 bits, lo = lower 32 bits.
  - multu: same, unsigned.
  - div: signed, quotient truncated toward zero into lo; remainder into hi, with the sign of the dividend.
  - divu: unsigned quotient into lo, remainder into hi.
  - Overflow, div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (div or divu): lo=0xFFFFFFFF, hi=a.
- Operands are sampled only at the start edge; later changes on a/b have no effect.
- hi/lo hold their value at all times except at a commit edge or an mthi/mtlo edge.
- done is registered and lasts exactly one cycle.

Test Plan:
- Reset: release reset, then start mult a=3 b=0xFFFFFFFE. Required: busy high cycles T+1..T+5; from T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA; done=1 only in T+6.
- divu a=100 b=7, then change a/b while busy. Required: busy for 10 cycles; then lo=14, hi=2; the operand changes have no effect.
- div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: divu a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234. A second start with mthi, issued while busy, is ignored (hi unchanged after commit).
- mtlo a=0xDEADBEEF in IDLE -> lo updates next edge, busy and done stay 0. Immediately follow with multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Reset mid-operation: drive reset low 2 cycles after a div start. Required: busy, hi, lo and done are 0 asynchronously; after release, no commit occurs and the state is IDLE.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the E stage: latches a 64-bit result at start,
// holds busy for a fixed latency, then commits it to HI/LO with a one-cycle done pulse.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] pendHi_q, pendLo_q;
    logic [31:0] hi_q, lo_q;
    logic        busy_q, done_q;

    logic [63:0] aSext, bSext, aZext, bZext, prodS, prodU;
    logic [31:0] absA, absB, qMag, rMag, qS, rS, qU, rU;
    logic [31:0] resHi_d, resLo_d;

    // Signed divide works on magnitudes; the 0x80000000 / -1 overflow case falls out naturally.
    always_comb begin
        aSext = {{32{a[31]}}, a};
        bSext = {{32{b[31]}}, b};
        aZext = {32'h0, a};
        bZext = {32'h0, b};
        prodS = aSext * bSext;
        prodU = aZext * bZext;
        absA  = a[31] ? (32'd0 - a) : a;
        absB  = b[31] ? (32'd0 - b) : b;
        qMag  = (absB == 32'd0) ? 32'd0 : absA / absB;
        rMag  = (absB == 32'd0) ? 32'd0 : absA % absB;
        qS    = (a[31] ^ b[31]) ? (32'd0 - qMag) : qMag;
        rS    = a[31] ? (32'd0 - rMag) : rMag;
        qU    = (b == 32'd0) ? 32'd0 : a / b;
        rU    = (b == 32'd0) ? 32'd0 : a % b;
        resHi_d = prodU[63:32];
        resLo_d = prodU[31:0];
        case (op)
            3'd0: begin
                resHi_d = prodS[63:32];
                resLo_d = prodS[31:0];
            end
            3'd2: begin
                resHi_d = (b == 32'd0) ? a : rS;
                resLo_d = (b == 32'd0) ? 32'hFFFF_FFFF : qS;
            end
            3'd3: begin
                resHi_d = (b == 32'd0) ? a : rU;
                resLo_d = (b == 32'd0) ? 32'hFFFF_FFFF : qU;
            end
            default: ;
        endcase
    end

    // Starts are only honoured in IDLE, so anything issued while busy is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            pendHi_q <= 32'd0;
            pendLo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op <= 3'd3) begin
                            pendHi_q <= resHi_d;
                            pendLo_q <= resLo_d;
                            cnt_q    <= op[1] ? DIV_LOAD : MULT_LOAD;
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end else if (op == 3'd4) begin
                            hi_q <= a;
                        end else if (op == 3'd5) begin
                            lo_q <= a;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q == 4'd1) begin
                        hi_q    <= pendHi_q;
                        lo_q    <= pendLo_q;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = (start && (op <= 3'd3)) || busy_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_mdu_sequencer;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] curHi = 32'd0;
    logic [31:0] curLo = 32'd0;

    mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference result {hi, lo} straight from the arithmetic rules.
    function automatic logic [63:0] refResult(input logic [2:0] opIn, input logic [31:0] x, input logic [31:0] y);
        longint      q, r;
        logic [63:0] ux, uy;
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (opIn)
            3'd0: return longint'($signed(x)) * longint'($signed(y));
            3'd1: return ux * uy;
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = longint'($signed(x)) / longint'($signed(y));
                r = longint'($signed(x)) % longint'($signed(y));
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues a mult/div in the current cycle and follows it cycle by cycle to the commit.
    task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                                 input logic [31:0] expHi, input logic [31:0] expLo,
                                 input bit intrude, input bit scramble);
        int n;
        n = opIn[1] ? DC : MC;
        start = 1'b1; op = opIn; a = aIn; b = bIn;
        #1;
        checkOutput("stallReqAtStart", 32'(stall_req), 32'd1);
        stepCycle();
        for (int i = 1; i <= n; i++) begin
            if (scramble) begin
                a = $urandom;
                b = $urandom;
            end
            if (intrude && i == 2) begin
                start = 1'b1; op = 3'd4; a = $urandom;
            end else begin
                start = 1'b0;
            end
            #1;
            checkOutput("busyInFlight", 32'(busy), 32'd1);
            checkOutput("doneInFlight", 32'(done), 32'd0);
            checkOutput("stallInFlight", 32'(stall_req), 32'd1);
            checkOutput("hiHeld", hi, curHi);
            checkOutput("loHeld", lo, curLo);
            stepCycle();
        end
        start = 1'b0;
        checkOutput("busyAfter", 32'(busy), 32'd0);
        checkOutput("donePulse", 32'(done), 32'd1);
        checkOutput("hiCommit", hi, expHi);
        checkOutput("loCommit", lo, expLo);
        curHi = expHi;
        curLo = expLo;
        stepCycle();
        checkOutput("doneOneCycle", 32'(done), 32'd0);
        checkOutput("hiStable", hi, curHi);
        checkOutput("loStable", lo, curLo);
    endtask

    task automatic applyMove(input logic [2:0] opIn, input logic [31:0] aIn);
        start = 1'b1; op = opIn; a = aIn; b = $urandom;
        #1;
        checkOutput("stallReqMove", 32'(stall_req), 32'd0);
        stepCycle();
        start = 1'b0;
        if (opIn == 3'd4) curHi = aIn;
        else curLo = aIn;
        checkOutput("hiMove", hi, curHi);
        checkOutput("loMove", lo, curLo);
        checkOutput("busyMove", 32'(busy), 32'd0);
        checkOutput("doneMove", 32'(done), 32'd0);
    endtask

    task automatic applyNop(input logic [2:0] opIn);
        start = 1'b1; op = opIn; a = $urandom; b = $urandom;
        stepCycle();
        start = 1'b0;
        checkOutput("busyNop", 32'(busy), 32'd0);
        checkOutput("doneNop", 32'(done), 32'd0);
        checkOutput("hiNop", hi, curHi);
        checkOutput("loNop", lo, curLo);
    endtask

    initial begin
        logic [63:0] exp64;
        logic [2:0]  rOp;
        logic [31:0] rA, rB;

        #1 reset = 1'b0;
        #2;
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetHi", hi, 32'd0);
        checkOutput("resetLo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        stepCycle();

        applyStimulus(3'd0, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
        applyStimulus(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        applyStimulus(3'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b0);
        applyStimulus(3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyMove(3'd5, 32'hDEAD_BEEF);
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        applyNop(3'd6);
        applyNop(3'd7);

        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
        stepCycle();
        start = 1'b0;
        stepCycle();
        checkOutput("busyBeforeAbort", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        checkOutput("abortHi", hi, 32'd0);
        checkOutput("abortLo", lo, 32'd0);
        checkOutput("abortStall", 32'(stall_req), 32'd0);
        stepCycle();
        stepCycle();
        reset = 1'b1;
        curHi = 32'd0;
        curLo = 32'd0;
        for (int i = 0; i < DC + 2; i++) begin
            stepCycle();
            checkOutput("postAbortBusy", 32'(busy), 32'd0);
            checkOutput("postAbortDone", 32'(done), 32'd0);
            checkOutput("postAbortHi", hi, 32'd0);
            checkOutput("postAbortLo", lo, 32'd0);
        end
        applyStimulus(3'd0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            rOp = 3'($urandom_range(0, 7));
            rA  = pickOperand();
            rB  = pickOperand();
            if (rOp <= 3'd3) begin
                exp64 = refResult(rOp, rA, rB);
                applyStimulus(rOp, rA, rB, exp64[63:32], exp64[31:0], 1'($urandom_range(0, 1)), 1'b1);
            end else if (rOp <= 3'd5) begin
                applyMove(rOp, rA);
            end else begin
                applyNop(rOp);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
